// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} arb_state_t;

    localparam int CNT_W = 4;

    function automatic int id_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and response handshake bundle for mult_arbiter.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int NREQ = 4
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [SIZE-1:0]   req_x [NREQ];
    logic [SIZE-1:0]   req_y [NREQ];
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*SIZE-1:0] resp_p;

    modport master (
        output req_valid, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_p
    );

    modport slave (
        input  req_valid, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_p
    );
endinterface

// File: rtl/mult_arbiter_mul.sv
// Unsigned shift-add array multiplier; purely combinational, full-width product.
module multiplier #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0]   x,
    input  logic [SIZE-1:0]   y,
    output logic [2*SIZE-1:0] p
);
    logic [2*SIZE-1:0] x_ext;
    logic [2*SIZE-1:0] acc;

    always_comb begin
        x_ext = {{SIZE{1'b0}}, x};
        acc   = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (y[i]) acc = acc + (x_ext << i);
        end
        p = acc;
    end
endmodule

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one combinational multiplier between NREQ requesters with round-robin
// grant, a programmable settle delay and a registered valid/ready response.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input logic          clk,
    input logic          reset,
    mult_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | arbitrate; grant is combinational, accept captures operands
    // CALC  | operands held, counting down settle cycles for the array
    // HOLD  | product registered, waiting for resp_ready
    localparam int IDW = id_w(NREQ);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    cur_id_q, cur_id_d;
    logic [SIZE-1:0]   op_x_q, op_x_d;
    logic [SIZE-1:0]   op_y_q, op_y_d;
    logic [2*SIZE-1:0] resp_p_q, resp_p_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic              resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic [2*SIZE-1:0] prod;

    // Grant is suppressed during reset so req_ready reads low while it is held.
    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .en     ((state_q == IDLE) && !reset),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    multiplier #(.SIZE(SIZE)) u_mul (
        .x (op_x_q),
        .y (op_y_q),
        .p (prod)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        cur_id_d     = cur_id_q;
        op_x_d       = op_x_q;
        op_y_d       = op_y_q;
        resp_p_d     = resp_p_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    op_x_d   = bus.req_x[gnt_id];
                    op_y_d   = bus.req_y[gnt_id];
                    cur_id_d = gnt_id;
                    cnt_d    = CNT_W'(SETTLE - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_p_d     = prod;
                    resp_id_d    = cur_id_q;
                    resp_valid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    rr_ptr_d     = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            cur_id_q     <= '0;
            op_x_q       <= '0;
            op_y_q       <= '0;
            resp_p_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_id_q     <= cur_id_d;
            op_x_q       <= op_x_d;
            op_y_q       <= op_y_d;
            resp_p_q     <= resp_p_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_p     = resp_p_q;
endmodule
